// File: rtl/bus_pkg.sv
// Shared address map, STATUS bit layout and target decode for the CPU data-side bus.
// Decode ignores byte-offset bits, so every access is treated as a whole word.
package bus_pkg;

    localparam logic [15:0] REGION_BASE   = 16'h0001;
    localparam logic [31:0] ADDR_GPIO_OUT = 32'h0001_0000;
    localparam logic [31:0] ADDR_GPIO_IN  = 32'h0001_0004;
    localparam logic [31:0] ADDR_CYCLES   = 32'h0001_0008;
    localparam logic [31:0] ADDR_TXDATA   = 32'h0001_000C;
    localparam logic [31:0] ADDR_STATUS   = 32'h0001_0010;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        T_RAM,
        T_GPO,
        T_GPI,
        T_CYC,
        T_TX,
        T_STAT,
        T_NONE
    } target_t;

    function automatic target_t decode_target(input logic [29:0] word_addr,
                                              input int unsigned ram_words);
        target_t t;
        t = T_NONE;
        if (word_addr[29:14] == 16'h0000) begin
            if ({18'b0, word_addr[13:0]} < ram_words) t = T_RAM;
        end else if (word_addr[29:14] == REGION_BASE) begin
            if      (word_addr == ADDR_GPIO_OUT[31:2]) t = T_GPO;
            else if (word_addr == ADDR_GPIO_IN[31:2])  t = T_GPI;
            else if (word_addr == ADDR_CYCLES[31:2])   t = T_CYC;
            else if (word_addr == ADDR_TXDATA[31:2])   t = T_TX;
            else if (word_addr == ADDR_STATUS[31:2])   t = T_STAT;
        end
        return t;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous first-word-fall-through FIFO; head valid the edge after a push.
// Backpressure: pushes while full and pops while empty are ignored; full is judged before the pop.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_bus.sv
// M-stage data port: decodes loads/stores onto RAM, GPIO, cycle counter and a TX byte FIFO.
// Reads are combinational (0 cycles), stores land at the edge; TX stream is valid/ready.
module data_bus
    import bus_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RIW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    ram [RAM_WORDS];
    logic [RIW-1:0] ram_idx;
    target_t        tgt;
    logic           wr;
    logic [7:0]     gpi_meta;
    logic [7:0]     gpi_sync;
    logic [31:0]    cycles;
    logic           ovf;
    logic           err;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           tx_push;
    logic [31:0]    status;
    logic           unused_byte_offset;

    assign unused_byte_offset = ^ALUOutM[1:0];
    assign tgt     = decode_target(ALUOutM[31:2], RAM_WORDS);
    assign ram_idx = ALUOutM[RIW+1:2];
    // Stores presented while reset is high are dropped everywhere, RAM included.
    assign wr      = MemWriteM && !reset;
    assign tx_push = wr && (tgt == T_TX);
    assign tx_valid = !fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (WriteDataM[7:0]),
        .pop       (tx_valid && tx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (tx_data)
    );

    always_ff @(posedge clk) begin
        if (wr && (tgt == T_RAM)) ram[ram_idx] <= WriteDataM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
            gpi_meta <= '0;
            gpi_sync <= '0;
            cycles   <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            gpi_meta <= gpio_in;
            gpi_sync <= gpi_meta;
            if (wr && (tgt == T_GPO)) gpio_out <= WriteDataM[7:0];
            if (wr && (tgt == T_CYC)) cycles <= WriteDataM;
            else                      cycles <= cycles + 32'd1;
            if (wr && (tgt == T_STAT)) begin
                ovf <= 1'b0;
                err <= 1'b0;
            end else begin
                if (tx_push && fifo_full) ovf <= 1'b1;
                if (wr && (tgt == T_NONE)) err <= 1'b1;
            end
        end
    end

    always_comb begin
        status = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_ERR]   = err;
        status[STAT_OVF]   = ovf;
        status[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
    end

    always_comb begin
        ReadDataM = '0;
        case (tgt)
            T_RAM:   ReadDataM = ram[ram_idx];
            T_GPO:   ReadDataM = {24'b0, gpio_out};
            T_GPI:   ReadDataM = {24'b0, gpi_sync};
            T_CYC:   ReadDataM = cycles;
            T_STAT:  ReadDataM = status;
            default: ReadDataM = '0;
        endcase
    end

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus: expected values are queued as stimulus is driven and popped at each check.
module tb_data_bus;

    localparam logic [31:0] A_GPO  = 32'h0001_0000;
    localparam logic [31:0] A_GPI  = 32'h0001_0004;
    localparam logic [31:0] A_CYC  = 32'h0001_0008;
    localparam logic [31:0] A_TX   = 32'h0001_000C;
    localparam logic [31:0] A_STAT = 32'h0001_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    data_bus #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    task automatic expect_val(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h but scoreboard had no expected value", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, e);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(exp);
        check(tag, obs);
    endtask

    // Loads sample the combinational read path in the same cycle, away from the edge.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        ALUOutM   = addr;
        MemWriteM = 1'b0;
        expect_val(exp);
        #1;
        check(tag, ReadDataM);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        ALUOutM    = addr;
        WriteDataM = data;
        MemWriteM  = 1'b1;
        @(negedge clk);
        MemWriteM  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
        gpio_in = 8'h00; tx_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk_out("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
        chk_out("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk_out("rst_tx_data", {24'b0, tx_data}, 32'h0);
        rd(A_CYC, 32'h0, "rst_cycles");
        rd(A_STAT, 32'h0000_0002, "rst_status");
        rd(A_GPI, 32'h0, "rst_gpio_in");

        reset = 1'b0;
        rd(A_CYC, 32'h0, "cycles_first");
        @(negedge clk);
        rd(A_CYC, 32'h1, "cycles_second");

        // RAM: word write/read, byte offsets ignored, neighbour untouched, top word
        wr(32'h0000_0014, 32'h1111_2222);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_offset_read");
        rd(32'h0000_0014, 32'h1111_2222, "ram_neighbour");
        wr(32'h0000_00FC, 32'h0BAD_F00D);
        rd(32'h0000_00FC, 32'h0BAD_F00D, "ram_last_word");
        wr(32'h0000_0020, 32'hCAFE_F00D);

        // GPIO
        wr(A_GPO, 32'h1234_56A5);
        chk_out("gpio_out", {24'b0, gpio_out}, 32'h0000_00A5);
        rd(A_GPO, 32'h0000_00A5, "gpio_out_read");
        @(negedge clk);
        gpio_in = 8'h3C;
        rd(A_GPI, 32'h0, "gpi_0_edges");
        @(negedge clk);
        rd(A_GPI, 32'h0, "gpi_1_edge");
        @(negedge clk);
        rd(A_GPI, 32'h0000_003C, "gpi_2_edges");

        // CYCLES load and wrap
        wr(A_CYC, 32'hFFFF_FFFE);
        rd(A_CYC, 32'hFFFF_FFFE, "cyc_load");
        @(negedge clk);
        rd(A_CYC, 32'hFFFF_FFFF, "cyc_max");
        @(negedge clk);
        rd(A_CYC, 32'h0000_0000, "cyc_wrap");

        // TX FIFO fill past full
        tx_ready = 1'b0;
        wr(A_TX, 32'hFFFF_FF01);
        chk_out("tx_valid_after_push", {31'b0, tx_valid}, 32'h1);
        for (int i = 2; i <= 9; i++) wr(A_TX, 32'(i));
        rd(A_STAT, 32'h0000_0809, "status_full_ovf");
        rd(A_TX, 32'h0, "txdata_reads_zero");
        chk_out("tx_head_1", {24'b0, tx_data}, 32'h01);

        // push while full with a simultaneous pop: push dropped
        wr(A_STAT, 32'h0);
        rd(A_STAT, 32'h0000_0801, "status_ovf_cleared");
        ALUOutM = A_TX; WriteDataM = 32'h77; MemWriteM = 1'b1; tx_ready = 1'b1;
        #1;
        chk_out("pop_head_1", {24'b0, tx_data}, 32'h01);
        @(negedge clk);
        MemWriteM = 1'b0; tx_ready = 1'b0;
        rd(A_STAT, 32'h0000_0708, "status_full_push_pop");

        tx_ready = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            #1;
            chk_out($sformatf("drain_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
            chk_out($sformatf("drain_data_%0d", i), {24'b0, tx_data}, 32'(i));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk_out("drained_valid", {31'b0, tx_valid}, 32'h0);
        chk_out("drained_data", {24'b0, tx_data}, 32'h0);
        rd(A_STAT, 32'h0000_000A, "status_empty");

        // simultaneous push and pop on a partly filled FIFO
        wr(A_TX, 32'hA1);
        wr(A_TX, 32'hA2);
        ALUOutM = A_TX; WriteDataM = 32'hA3; MemWriteM = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        MemWriteM = 1'b0; tx_ready = 1'b0;
        rd(A_STAT, 32'h0000_0208, "status_push_pop_same");
        chk_out("head_after_push_pop", {24'b0, tx_data}, 32'hA2);

        // unmapped and out-of-range RAM accesses
        wr(32'h0002_0000, 32'h1234_5678);
        rd(32'h0002_0000, 32'h0, "unmapped_read");
        wr(32'h0000_0100, 32'h5555_5555);
        rd(32'h0000_0100, 32'h0, "ram_beyond_read");
        rd(A_STAT, 32'h0000_020C, "status_err");
        wr(A_STAT, 32'hFFFF_FFFF);
        rd(A_STAT, 32'h0000_0200, "status_cleared");

        // reset mid-traffic with 3 bytes queued and a store in flight
        wr(A_TX, 32'hB1);
        rd(A_STAT, 32'h0000_0300, "status_three_queued");
        reset = 1'b1;
        ALUOutM = 32'h0000_0020; WriteDataM = 32'h0000_0055; MemWriteM = 1'b1;
        @(negedge clk);
        MemWriteM = 1'b0;
        chk_out("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk_out("reset_tx_data", {24'b0, tx_data}, 32'h0);
        chk_out("reset_gpio_out", {24'b0, gpio_out}, 32'h0);
        rd(A_STAT, 32'h0000_0002, "reset_status");
        reset = 1'b0;
        rd(32'h0000_0020, 32'hCAFE_F00D, "store_during_reset_ignored");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
